// File: rtl/sort4_ctrl_pkg.sv
// rtl/sort4_ctrl_pkg.sv - shared state encoding and batch constants for sort4_ctrl
package sort4_ctrl_pkg;

    // Controller states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SORT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int DEPTH    = 4;
    localparam int MAX_PASS = 3;

    // Index limits in the 2-bit index width used by the controller
    localparam logic [1:0] LAST_IDX  = 2'(DEPTH - 1);
    localparam logic [1:0] LAST_J    = 2'(DEPTH - 2);
    localparam logic [1:0] LAST_PASS = 2'(MAX_PASS - 1);

endpackage

// File: rtl/sort4_ctrl_byte_comparator.sv
// rtl/sort4_ctrl_byte_comparator.sv - combinational unsigned magnitude comparator
//
// Ports:
//   a, b : WIDTH-bit unsigned operands
//   lt   : a < b
//   gt   : a > b   (both low when a == b)
module byte_comparator #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt,
    output logic             gt
);

    assign lt = (a < b);
    assign gt = (a > b);

endmodule

// File: rtl/sort4_ctrl.sv
// rtl/sort4_ctrl.sv - 4-entry in-place bubble sort controller with one shared comparator
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : begin a new batch (honoured in IDLE only)
//   in_valid/in_data     : load stream, in_ready high only in LOAD
//   out_valid/out_data   : sorted ascending output stream, valid only in DRAIN
//   out_ready            : consumer accept
//   busy                 : high in any state other than IDLE
//   done                 : one-cycle pulse after the last output is accepted
//   swap_count           : swaps performed for the current batch (0..6)
module sort4_ctrl
    import sort4_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [2:0]       swap_count
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [1:0]       ld_idx_q, ld_idx_d;
    logic [1:0]       rd_idx_q, rd_idx_d;
    logic [1:0]       j_q, j_d;
    logic [1:0]       pass_q, pass_d;
    logic             dirty_q, dirty_d;      // a swap has happened in the current pass
    logic [2:0]       swap_count_q, swap_count_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic [WIDTH-1:0] cmp_a, cmp_b;
    logic             cmp_lt, cmp_gt;
    logic             do_swap;

    // The single comparator always looks at the adjacent pair selected by j
    assign cmp_a = regs_q[j_q];
    assign cmp_b = regs_q[j_q + 2'd1];

    byte_comparator #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .lt (cmp_lt),
        .gt (cmp_gt)
    );

    // Equal entries raise neither flag, so they keep their order
    assign do_swap = cmp_gt && !cmp_lt;

    always_comb begin
        state_d      = state_q;
        regs_d       = regs_q;
        ld_idx_d     = ld_idx_q;
        rd_idx_d     = rd_idx_q;
        j_d          = j_q;
        pass_d       = pass_q;
        dirty_d      = dirty_q;
        swap_count_d = swap_count_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    swap_count_d = 3'd0;
                    ld_idx_d     = 2'd0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    regs_d[ld_idx_q] = in_data;
                    ld_idx_d         = ld_idx_q + 2'd1;
                    if (ld_idx_q == LAST_IDX) begin
                        state_d = ST_SORT;
                        j_d     = 2'd0;
                        pass_d  = 2'd0;
                        dirty_d = 1'b0;
                    end
                end
            end
            ST_SORT: begin
                if (do_swap) begin
                    regs_d[j_q]         = cmp_b;
                    regs_d[j_q + 2'd1]  = cmp_a;
                    swap_count_d        = swap_count_q + 3'd1;
                end
                if (j_q == LAST_J) begin
                    // End of a pass: a clean pass means sorted; after the last pass
                    // the array is sorted regardless.
                    if (!(dirty_q || do_swap) || (pass_q == LAST_PASS)) begin
                        state_d  = ST_DRAIN;
                        rd_idx_d = 2'd0;
                    end else begin
                        j_d     = 2'd0;
                        pass_d  = pass_q + 2'd1;
                        dirty_d = 1'b0;
                    end
                end else begin
                    j_d     = j_q + 2'd1;
                    dirty_d = dirty_q || do_swap;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    rd_idx_d = rd_idx_q + 2'd1;
                    if (rd_idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Register the entry that will be presented next cycle
        out_data_d = (state_d == ST_DRAIN) ? regs_d[rd_idx_d] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            ld_idx_q     <= 2'd0;
            rd_idx_q     <= 2'd0;
            j_q          <= 2'd0;
            pass_q       <= 2'd0;
            dirty_q      <= 1'b0;
            swap_count_q <= 3'd0;
            done_q       <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            regs_q       <= regs_d;
            ld_idx_q     <= ld_idx_d;
            rd_idx_q     <= rd_idx_d;
            j_q          <= j_d;
            pass_q       <= pass_d;
            dirty_q      <= dirty_d;
            swap_count_q <= swap_count_d;
            done_q       <= done_d;
            out_data_q   <= out_data_d;
        end
    end

    assign in_ready   = (state_q == ST_LOAD);
    assign out_valid  = (state_q == ST_DRAIN);
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign out_data   = out_data_q;
    assign swap_count = swap_count_q;

endmodule

// File: tb/tb_sort4_ctrl.sv
// tb/tb_sort4_ctrl.sv - table-driven self-checking bench for sort4_ctrl
module tb_sort4_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic [2:0] swap_count;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    sort4_ctrl #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .swap_count (swap_count)
    );

    typedef struct packed {
        logic [3:0][7:0] din;
        logic [3:0][7:0] exp;
        logic [2:0]      swaps;
        logic [3:0]      sort_cyc;
        logic            gaps;   // insert in_valid=0 beats during LOAD
        logic            bp;     // out_ready pattern 1,0,0,1,...
        logic            sis;    // pulse start during SORT
    } vec_t;

    vec_t vecs [5];

    function automatic vec_t mk(input logic [7:0] a0, a1, a2, a3,
                                input logic [7:0] e0, e1, e2, e3,
                                input logic [2:0] sw, input logic [3:0] sc,
                                input logic g, b, s);
        vec_t v;
        v.din[0] = a0; v.din[1] = a1; v.din[2] = a2; v.din[3] = a3;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        v.swaps = sw; v.sort_cyc = sc; v.gaps = g; v.bp = b; v.sis = s;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic load_batch(input vec_t v);
        int  k;
        int  cyc;
        logic acc;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 50) begin
            @(negedge clk);
            start = 1'b0;
            if (v.gaps && cyc[0]) begin
                in_valid = 1'b0;
                in_data  = 8'hEE;
            end else begin
                in_valid = 1'b1;
                in_data  = v.din[k];
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) k++;
            cyc++;
        end
        chk("load_beats", k, 4);
    endtask

    task automatic run_batch(input vec_t v);
        int   sc;
        int   g;
        int   r;
        int   cyc;
        int   p;
        logic stalled;
        logic [7:0] held;
        load_batch(v);
        sc = 0;
        g  = 0;
        while (g < 40) begin
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
            if (out_valid) break;
            sc++;
            if (v.sis && sc == 1) start = 1'b1;
            if (v.sis && sc == 2) chk("no_restart", {30'd0, in_ready, busy}, 1);
            g++;
        end
        chk("sort_cycles", sc, int'(v.sort_cyc));
        r = 0;
        cyc = 0;
        p = 0;
        stalled = 1'b0;
        held = 8'd0;
        while (r < 4 && cyc < 100) begin
            if (out_valid) begin
                if (stalled) chk("out_hold", out_data, held);
                chk("done_low_in_drain", done, 0);
                out_ready = v.bp ? ((p % 4 == 0) || (p % 4 == 3)) : 1'b1;
                p++;
                if (out_ready) begin
                    chk("out_data", out_data, v.exp[r]);
                    r++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = out_data;
                end
            end else begin
                out_ready = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_beats", r, 4);
        chk("done_pulse", done, 1);
        chk("idle_after", {31'd0, busy}, 0);
        chk("swap_count", swap_count, int'(v.swaps));
        @(negedge clk);
        chk("done_single", done, 0);
        chk("swap_hold", swap_count, int'(v.swaps));
    endtask

    initial begin
        vecs[0] = mk(8'd1, 8'd2, 8'd3, 8'd4,       8'd1, 8'd2, 8'd3, 8'd4,       3'd0, 4'd3, 1'b0, 1'b0, 1'b0);
        vecs[1] = mk(8'd200, 8'd150, 8'd100, 8'd50, 8'd50, 8'd100, 8'd150, 8'd200, 3'd6, 4'd9, 1'b0, 1'b0, 1'b0);
        vecs[2] = mk(8'd7, 8'd7, 8'd3, 8'd7,       8'd3, 8'd7, 8'd7, 8'd7,       3'd2, 4'd9, 1'b0, 1'b0, 1'b0);
        vecs[3] = mk(8'd9, 8'd0, 8'd5, 8'd2,       8'd0, 8'd2, 8'd5, 8'd9,       3'd4, 4'd9, 1'b1, 1'b1, 1'b1);
        vecs[4] = mk(8'd5, 8'd1, 8'd2, 8'd3,       8'd1, 8'd2, 8'd3, 8'd5,       3'd3, 4'd6, 1'b0, 1'b0, 1'b0);

        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_swap_count", swap_count, 0);
        rst_n = 1'b1;

        // IDLE ignores in_valid/out_ready
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("idle_ignore", {29'd0, busy, in_ready, out_valid}, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_batch(vecs[i]);
        end

        // Reset asserted in the middle of SORT
        load_batch(vecs[1]);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_sort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_done", done, 0);
        chk("mrst_out_data", out_data, 0);
        chk("mrst_swap_count", swap_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_batch(mk(8'd4, 8'd3, 8'd2, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 3'd6, 4'd9, 1'b0, 1'b0, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sort4_ctrl.md
Name: sort4_ctrl

Overview:
Sequencing controller that sorts a 4-entry batch of unsigned 8-bit values ascending, using one shared combinational 8-bit magnitude comparator.
- Flow: load 4 bytes over a valid/ready input stream, bubble-sort them in place (one compare per cycle, early exit), then stream the result out over a valid/ready output port.
- Sits between a byte producer and consumer as the block that schedules the comparator datapath.

Parameters:
WIDTH, 8, data width of each entry and of the comparator (batch depth is fixed at 4)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a new batch; honoured only in IDLE
in_valid  input  1  in_data is valid
in_data  input  WIDTH  entry to load
in_ready  output  1  high only in LOAD
out_valid  output  1  high only in DRAIN
out_data  output  WIDTH  current sorted entry (ascending)
out_ready  input  1  consumer accepts out_data
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last entry is accepted
swap_count  output  3  swaps performed for the current batch, 0..6

Behaviour:
- Reset (async, rst_n=0), effective immediately, mid-operation included:
  - state=IDLE; all four entry registers, all indices and swap_count cleared to 0.
  - in_ready=0, out_valid=0, busy=0, done=0, out_data=0.
- States: IDLE, LOAD, SORT, DRAIN.
- IDLE: start=1 -> LOAD next cycle; swap_count cleared on that transition. in_valid/out_ready ignored.
- LOAD: in_ready=1.
  - Each cycle with in_valid&in_ready writes in_data to reg[ld_idx]; ld_idx advances 0..3.
  - The 4th accept -> SORT next cycle. in_valid=0 cycles simply stall.
- SORT: one comparison per cycle of reg[j] vs reg[j+1] through the shared comparator.
  - j runs 0,1,2 per pass; at most 3 passes.
  - gt=1: swap both registers at the clock edge and increment swap_count.
  - Equal values are never swapped (stable).
  - At j=2: if the current pass had no swap (including this cycle's compare), or this is pass 3 -> DRAIN. Otherwise j=0 and pass+1.
  - Cycles in SORT: 3 for already-sorted input, 9 worst case.
- DRAIN: out_valid=1, out_data=reg[rd_idx] (registered; holds stable until accepted).
  - rd_idx advances on out_valid&out_ready.
  - After the 4th accept: IDLE next cycle, with done=1 for exactly that one cycle.
- swap_count holds its value through DRAIN and IDLE until the next start.
- start while busy: ignored, no effect.
- in_valid outside LOAD and out_ready outside DRAIN: ignored.
- Unsigned comparison only; no wrap-around or saturation (max 6 swaps fits in 3 bits).

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE, ST_LOAD, ST_SORT, ST_DRAIN (2 bits).
  - DEPTH=4.
  - MAX_PASS=3.
- Sub-module: byte_comparator (combinational WIDTH-bit unsigned lt/gt), instantiated exactly once and muxed by j. No other sub-modules.

Test Plan:
- Load [1,2,3,4] with in_valid held high -> SORT lasts 3 cycles; swap_count=0; out stream 1,2,3,4; done pulses once.
- Load [200,150,100,50] -> SORT lasts 9 cycles; swap_count=6; out 50,100,150,200.
- Load [7,7,3,7] -> swap_count=2; out 3,7,7,7; equal entries never swapped.
- Back-pressure: out_ready toggling 1,0,0,1,... on [9,0,5,2] -> out_data stable while stalled; sequence 0,2,5,9; no entry dropped or duplicated.
- Stalls and ignores: in_valid gaps during LOAD -> only valid beats are captured; start pulsed during SORT -> no restart, busy stays 1.
- Reset asserted mid-SORT -> outputs immediately at reset values. After release, start followed by loading [4,3,2,1] -> out 1,2,3,4; swap_count=6.
